// File: rtl/slv_mem_pkg.sv
// slv_mem shared types and constants.
// Status map and counter limit apply when SLV_MEM_STATS_EN is defined.
package slv_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  localparam logic [7:0] STAT_WCNT_A = 8'hF0;
  localparam logic [7:0] STAT_RCNT_A = 8'hF1;
  localparam logic [7:0] STAT_ECNT_A = 8'hF2;
  localparam logic [7:0] STAT_CLR_A  = 8'hF3;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
  } rd_stage_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/slv_mem_stat.sv
// slv_stat_regs: saturating write/read/error counters.
// Only instantiated when SLV_MEM_STATS_EN is defined.
module slv_stat_regs
  import slv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_acc_i,
  input  logic        rd_i,
  input  logic        wr_rej_i,
  input  logic        clr_i,
  input  logic [1:0]  sel_i,
  output logic [15:0] rd_data_o
);

  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic [15:0] ecnt_q, ecnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    ecnt_d = ecnt_q;
    if (wr_acc_i) wcnt_d = sat_inc(wcnt_q);
    if (rd_i)     rcnt_d = sat_inc(rcnt_q);
    if (wr_rej_i) ecnt_d = sat_inc(ecnt_q);
    // Clear overrides any increment at the same edge
    if (clr_i) begin
      wcnt_d = '0;
      rcnt_d = '0;
      ecnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      ecnt_q <= ecnt_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    unique case (sel_i)
      2'd0:    rd_data_o = wcnt_q;
      2'd1:    rd_data_o = rcnt_q;
      2'd2:    rd_data_o = ecnt_q;
      default: rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/slv_mem.sv
// slv_mem: one transaction per clock, 3-stage registered read path.
// Define SLV_MEM_STATS_EN to map status counters at 0xF0-0xF3.
module slv_mem
  import slv_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              wr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;

  rd_stage_t         s1_q, s1_d, s2_q;
  logic [DATA_W-1:0] dout_q;
  logic              rdv_q;

`ifdef SLV_MEM_STATS_EN
  logic        stat_hit;
  logic        stat_rej;
  logic        stat_clr;
  logic [15:0] stat_rd;
  logic        err_q;

  assign stat_hit = (address >= ADDR_W'(STAT_WCNT_A))
                 && (address <= ADDR_W'(STAT_CLR_A));
  assign stat_clr = write && (address == ADDR_W'(STAT_CLR_A));
  assign stat_rej = write && stat_hit && !stat_clr;
  assign wr_en    = write && !stat_hit;
  assign rd_word  = stat_hit ? DATA_W'(stat_rd)
                             : mem_q[address];

  slv_stat_regs u_stat (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_acc_i  (wr_en),
    .rd_i      (!write),
    .wr_rej_i  (stat_rej),
    .clr_i     (stat_clr),
    .sel_i     (address[1:0]),
    .rd_data_o (stat_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= stat_rej;
  end

  assign wr_err = err_q;
`else
  assign wr_en   = write;
  assign rd_word = mem_q[address];
  assign wr_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[address] <= data_in;
    end
  end

  // Stage 1 samples storage before this edge's write lands
  always_comb begin
    s1_d       = '0;
    s1_d.valid = !write;
    s1_d.data  = rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      dout_q <= '0;
      rdv_q  <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s1_q;
      rdv_q <= s2_q.valid;
      if (s2_q.valid) dout_q <= s2_q.data;
    end
  end

  assign data_out = dout_q;
  assign rd_valid = rdv_q;

endmodule

// File: tb/tb_slv_mem.sv
// Self-checking bench for slv_mem with a queue-based reference model.
// Status-counter scenarios run when SLV_MEM_STATS_EN is defined.
module tb_slv_mem;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [7:0]  address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        wr_err;

  int checks   = 0;
  int failures = 0;

  slv_mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .write    (write),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .wr_err   (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] d;
  } exp_t;

  logic [15:0] mmem [256];
  exp_t        pend [$];
  logic [15:0] last_d;
  int          edge_n;
  int          wcnt, rcnt, ecnt;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mmem[i] = 16'h0000;
    pend.delete();
    last_d = 16'h0000;
    wcnt = 0;
    rcnt = 0;
    ecnt = 0;
  endtask

  function automatic logic [15:0] model_read(input logic [7:0] a);
`ifdef SLV_MEM_STATS_EN
    if (a == 8'hF0) return 16'(wcnt);
    if (a == 8'hF1) return 16'(rcnt);
    if (a == 8'hF2) return 16'(ecnt);
    if (a == 8'hF3) return 16'h0000;
`endif
    return mmem[a];
  endfunction

  // One transaction at the next posedge; checks outputs 1ns after it.
  task automatic step(input logic w, input logic [7:0] a,
                      input logic [15:0] d);
    logic exp_err;
    logic exp_v;
    write   = w;
    address = a;
    data_in = d;
    exp_err = 1'b0;
    if (!w) begin
      pend.push_back('{due: edge_n + 3, d: model_read(a)});
      if (rcnt < 65535) rcnt++;
    end else begin
`ifdef SLV_MEM_STATS_EN
      if (a >= 8'hF0 && a <= 8'hF2) begin
        exp_err = 1'b1;
        if (ecnt < 65535) ecnt++;
      end else if (a == 8'hF3) begin
        wcnt = 0;
        rcnt = 0;
        ecnt = 0;
      end else begin
        mmem[a] = d;
        if (wcnt < 65535) wcnt++;
      end
`else
      mmem[a] = d;
      if (wcnt < 65535) wcnt++;
`endif
    end
    @(posedge clk);
    edge_n++;
    #1;
    exp_v = (pend.size() > 0) && (pend[0].due == edge_n);
    if (exp_v) begin
      last_d = pend[0].d;
      void'(pend.pop_front());
    end
    checks++;
    if (rd_valid !== exp_v) begin
      failures++;
      $display("FAIL rd_valid edge=%0d got=%b exp=%b",
               edge_n, rd_valid, exp_v);
    end
    checks++;
    if (data_out !== last_d) begin
      failures++;
      $display("FAIL data_out edge=%0d got=%h exp=%h",
               edge_n, data_out, last_d);
    end
    checks++;
    if (wr_err !== exp_err) begin
      failures++;
      $display("FAIL wr_err edge=%0d got=%b exp=%b",
               edge_n, wr_err, exp_err);
    end
  endtask

  task automatic reset_dut();
    #2 rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (data_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_dout got=%h exp=0000", data_out);
    end
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdv got=%b exp=0", rd_valid);
    end
    checks++;
    if (wr_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b exp=0", wr_err);
    end
    rst_n = 1'b1;
    step(1'b0, 8'h55, 16'h0);
    step(1'b0, 8'hFF, 16'h0);
    step(1'b1, 8'hA0, 16'h0);
    step(1'b1, 8'hA0, 16'h0);
  endtask

  task automatic test_write_read();
    step(1'b1, 8'h12, 16'hBEEF);
    step(1'b0, 8'h12, 16'h0);
    step(1'b1, 8'hA0, 16'h0);
    step(1'b1, 8'hA0, 16'h0);
    checks++;
    if (rd_valid !== 1'b1 || data_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL wr_rd got=%b/%h exp=1/beef", rd_valid, data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [3];
    exp_q[0] = 16'h1111;
    exp_q[1] = 16'h2222;
    exp_q[2] = 16'h3333;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i), exp_q[i]);
    step(1'b0, 8'h00, 16'h0);
    step(1'b0, 8'h01, 16'h0);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(1'b0, 8'h02, 16'h0);
      else        step(1'b1, 8'hA1, 16'h0);
      checks++;
      if (rd_valid !== 1'b1 || data_out !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b[%0d] got=%b/%h exp=1/%h",
                 i, rd_valid, data_out, exp_q[i]);
      end
    end
  endtask

  task automatic test_rd_then_wr();
    step(1'b1, 8'h40, 16'h5555);
    step(1'b0, 8'h40, 16'h0);
    step(1'b1, 8'h40, 16'hAAAA);
    step(1'b1, 8'hA2, 16'h0);
    checks++;
    if (rd_valid !== 1'b1 || data_out !== 16'h5555) begin
      failures++;
      $display("FAIL rd_wr_order got=%b/%h exp=1/5555",
               rd_valid, data_out);
    end
    step(1'b0, 8'h40, 16'h0);
    step(1'b1, 8'hA2, 16'h0);
    step(1'b1, 8'hA2, 16'h0);
    checks++;
    if (data_out !== 16'hAAAA) begin
      failures++;
      $display("FAIL rd_after_wr got=%h exp=aaaa", data_out);
    end
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 8'h12, 16'hCAFE);
    step(1'b0, 8'h12, 16'h0);
    step(1'b1, 8'hA3, 16'h0);
    reset_dut();
    checks++;
    if (rd_valid !== 1'b0 || data_out !== 16'h0000) begin
      failures++;
      $display("FAIL rst_inflight got=%b/%h exp=0/0000",
               rd_valid, data_out);
    end
    step(1'b0, 8'h12, 16'h0);
    step(1'b1, 8'hA3, 16'h0);
    step(1'b1, 8'hA3, 16'h0);
    checks++;
    if (rd_valid !== 1'b1 || data_out !== 16'h0000) begin
      failures++;
      $display("FAIL rst_cleared got=%b/%h exp=1/0000",
               rd_valid, data_out);
    end
  endtask

  task automatic test_addr_edges();
    step(1'b1, 8'h00, 16'h0F0F);
    step(1'b1, 8'hEF, 16'h7E7E);
`ifndef SLV_MEM_STATS_EN
    step(1'b1, 8'hFF, 16'hF00D);
    step(1'b0, 8'hFF, 16'h0);
`endif
    step(1'b0, 8'h00, 16'h0);
    step(1'b0, 8'hEF, 16'h0);
    repeat (3) step(1'b1, 8'hA4, 16'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom),
           16'($urandom));
    end
    repeat (3) step(1'b1, 8'hA5, 16'h0);
  endtask

`ifdef SLV_MEM_STATS_EN
  task automatic test_stats();
    reset_dut();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h10, 16'(i));
    step(1'b1, 8'hF1, 16'h7777);
    checks++;
    if (wr_err !== 1'b1) begin
      failures++;
      $display("FAIL stat_err got=%b exp=1", wr_err);
    end
    step(1'b0, 8'hF0, 16'h0);
    step(1'b0, 8'hF2, 16'h0);
    step(1'b1, 8'hA6, 16'h0);
    checks++;
    if (data_out !== 16'h0003) begin
      failures++;
      $display("FAIL stat_wcnt got=%h exp=0003", data_out);
    end
    step(1'b1, 8'hF3, 16'h0);
    checks++;
    if (data_out !== 16'h0001) begin
      failures++;
      $display("FAIL stat_ecnt got=%h exp=0001", data_out);
    end
    step(1'b0, 8'hF1, 16'h0);
    step(1'b0, 8'hF0, 16'h0);
    step(1'b0, 8'hF2, 16'h0);
    step(1'b0, 8'hF3, 16'h0);
    repeat (3) step(1'b1, 8'hA6, 16'h0);
  endtask

  task automatic test_saturate();
    reset_dut();
    for (int i = 0; i < 65536; i++) step(1'b0, 8'h20, 16'h0);
    step(1'b0, 8'hF1, 16'h0);
    step(1'b1, 8'hA7, 16'h0);
    step(1'b1, 8'hA7, 16'h0);
    checks++;
    if (rd_valid !== 1'b1 || data_out !== 16'hFFFF) begin
      failures++;
      $display("FAIL stat_sat got=%b/%h exp=1/ffff",
               rd_valid, data_out);
    end
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    write   = 1'b0;
    address = 8'h00;
    data_in = 16'h0000;
    edge_n  = 0;
    model_clear();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_rd_then_wr();
    test_reset_inflight();
    test_addr_edges();
    test_random();
`ifdef SLV_MEM_STATS_EN
    test_stats();
    test_saturate();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slv_mem.md
SLV_MEM -- requirements
Module: slv_mem

Interface
REQ-001 Parameters: DATA_W, 16, data word width.
REQ-002 Parameters: ADDR_W, 8, address width (2**ADDR_W words).
REQ-003 Ports: clk  input  1  single clock; all sampling on posedge.
REQ-004 Ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Ports: write  input  1  1 = write cycle, 0 = read cycle, sampled every posedge.
REQ-006 Ports: address  input  ADDR_W  word address.
REQ-007 Ports: data_in  input  DATA_W  write data.
REQ-008 Ports: data_out  output  DATA_W  read data, registered.
REQ-009 Ports: rd_valid  output  1  one-cycle pulse, data_out carries new read data.
REQ-010 Ports: wr_err  output  1  one-cycle pulse, rejected write.

Function
REQ-011 Every posedge with rst_n high SHALL be one transaction: write=1 write, write=0 read; no idle state.
REQ-012 Accepted write at edge N SHALL update storage at edge N; visible to reads sampled at edge N+1 onward.
REQ-013 Read at edge N SHALL latch storage at edge N (stage 1), drive data_out at edge N+2, rd_valid high for the cycle after edge N+2.
REQ-014 Read pipeline SHALL accept one read per cycle; back-to-back reads give back-to-back rd_valid, in order.
REQ-015 data_out SHALL hold its last value while rd_valid is low.
REQ-016 Read data SHALL reflect all writes sampled before its edge and none after, regardless of pipeline overlap.
REQ-017 Address decode SHALL be full ADDR_W; no aliasing, no wrap beyond 2**ADDR_W-1.

Reset
REQ-018 rst_n low SHALL asynchronously clear storage to 0x0000, data_out to 0x0000, rd_valid and wr_err to 0, pipeline valid bits and counters to 0.
REQ-019 Reads in flight at reset assertion SHALL be discarded; no rd_valid for them after release.
REQ-020 First transaction SHALL be sampled at the first posedge with rst_n high.

Configuration
REQ-021 Macro SLV_MEM_STATS_EN SHALL enable status registers: 0xF0 write count, 0xF1 read count, 0xF2 error count, 0xF3 clear.
REQ-022 With macro: counters 16-bit, saturate at 0xFFFF; write count = accepted writes, read count = all reads, error count = rejected writes.
REQ-023 With macro: writes to 0xF0-0xF2 SHALL be rejected (storage unchanged, wr_err pulse the cycle after edge, error count +1).
REQ-024 With macro: any write to 0xF3 SHALL clear all three counters at that edge; clear wins over its own increment.
REQ-025 With macro: a read of a counter SHALL return the value before that read's own increment; read of 0xF3 returns 0x0000.
REQ-026 Without macro: all addresses plain storage, wr_err tied 0, no counter logic present.

Structure
REQ-027 Package slv_mem_pkg SHALL hold DATA_W/ADDR_W defaults, status address constants (0xF0-0xF3), counter max, and the read-pipeline stage struct typedef (valid, data).
REQ-028 Counters SHALL live in one sub-module slv_stat_regs, instantiated only under SLV_MEM_STATS_EN.

Verification
REQ-029 Write 0x12 <= 0xBEEF, then read 0x12 next cycle -> data_out=0xBEEF, rd_valid pulse 2 edges after read edge.
REQ-030 Reads 0x00,0x01,0x02 on consecutive edges after writes 0x1111/0x2222/0x3333 -> three consecutive rd_valid pulses, data in order.
REQ-031 Read 0x40 at edge N, write 0x40 <= 0xAAAA at N+1 (old 0x5555) -> returned data 0x5555.
REQ-032 Reset asserted one cycle after read issued -> no rd_valid, data_out=0x0000, read 0x12 after release -> 0x0000.
REQ-033 Macro on: 3 writes to 0x10, write 0xF1 <= 0x7777 -> wr_err pulse; read 0xF0 -> 0x0003, read 0xF2 -> 0x0001; write 0xF3 -> all counters read 0x0000.
REQ-034 Macro on: force read count to 0xFFFF via 65535 reads, one more read -> read 0xF1 returns 0xFFFF (saturated).
